// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating sequencer: each lane gates its domain clock after a
// software request plus an idle hysteresis window, and re-enables it on wake with a settle delay.
module clk_gate_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic [NUM_DOMAINS-1:0] gate_req_i,
  input  logic [NUM_DOMAINS-1:0] wake_req_i,
  input  logic [NUM_DOMAINS-1:0] idle_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] ready_o,
  output logic [NUM_DOMAINS-1:0] gated_o,
  output logic                   all_gated_o
);

  localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } lane_state_e;

  logic [NUM_DOMAINS-1:0] w_clk_en;
  logic [NUM_DOMAINS-1:0] w_ready;
  logic [NUM_DOMAINS-1:0] w_gated;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : gen_lane
    lane_state_e   r_state;
    logic [CW-1:0] r_cnt;

    // NOTE: state flops use non-blocking assignments so every lane samples
    // the pre-edge values; the async reset drops the lane straight to ON.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= ST_ON;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_ON: begin
            if (gate_req_i[d] && !wake_req_i[d]) begin
              r_state <= ST_DRAIN;
              r_cnt   <= '0;
            end
          end
          ST_DRAIN: begin
            if (wake_req_i[d] || !gate_req_i[d]) begin
              r_state <= ST_ON;
            end else if (idle_i[d] && (r_cnt == IDLE_LAST)) begin
              r_state <= ST_OFF;
            end else if (idle_i[d]) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt <= '0;  // any busy cycle restarts the hysteresis window
            end
          end
          ST_OFF: begin
            if (wake_req_i[d] || !gate_req_i[d]) begin
              r_state <= ST_WAKE;
              r_cnt   <= '0;
            end
          end
          ST_WAKE: begin
            // Settle window is never aborted; requests are re-evaluated in ON.
            if (r_cnt == WAKE_LAST) begin
              r_state <= ST_ON;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_ON;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_clk_en[d] = (r_state != ST_OFF);
    assign w_ready[d]  = (r_state == ST_ON);
    assign w_gated[d]  = (r_state == ST_OFF);
  end

  // DFT override is the only input that reaches an output combinationally.
  assign clk_en_o    = w_clk_en | {NUM_DOMAINS{test_mode_i}};
  assign ready_o     = w_ready;
  assign gated_o     = w_gated;
  assign all_gated_o = &w_gated;

endmodule
